// File: rtl/argmin_sequencer.sv
// argmin_sequencer: per-pixel disparity selector. One combinational argmin
// over INPUTS lanes is reused across CHUNKS beats; a running minimum/index is
// kept across beats and one (value, index) result is emitted per pixel.
// Optional macro ARGMIN_SEQ_LAST_CHECK_EN adds in_last/err framing check.

// Combinational argmin over INPUTS packed words; ties resolve to the lower lane.
module argmin #(
   parameter int WIDTH  = 7,
   parameter int INPUTS = 8,
   localparam int SEL_W = $clog2(INPUTS)
) (
   input  logic [WIDTH*INPUTS-1:0] words,
   output logic [WIDTH-1:0]        min_value,
   output logic [SEL_W-1:0]        min_index
);

   logic [WIDTH-1:0] lane_word [INPUTS];
   logic [WIDTH-1:0] red_val   [INPUTS];
   logic [SEL_W-1:0] red_idx   [INPUTS];

   for (genvar gi = 0; gi < INPUTS; gi++) begin : g_lane
      assign lane_word[gi] = words[gi*WIDTH +: WIDTH];
   end

   // Pairwise tree reduction in place; the right operand only wins when
   // strictly smaller, so equal costs keep the lower lane.
   always_comb begin
      for (int i = 0; i < INPUTS; i++) begin
         red_val[i] = lane_word[i];
         red_idx[i] = SEL_W'(i);
      end
      for (int s = 1; s < INPUTS; s = s * 2) begin
         for (int i = 0; i < INPUTS; i = i + 2 * s) begin
            if (red_val[i+s] < red_val[i]) begin
               red_val[i] = red_val[i+s];
               red_idx[i] = red_idx[i+s];
            end
         end
      end
      min_value = red_val[0];
      min_index = red_idx[0];
   end

endmodule

module argmin_sequencer #(
   parameter int WIDTH  = 7,
   parameter int INPUTS = 8,
   parameter int CHUNKS = 8,
   localparam int IDX_WIDTH = $clog2(INPUTS*CHUNKS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH*INPUTS-1:0]   in_words,
`ifdef ARGMIN_SEQ_LAST_CHECK_EN
   input  logic                      in_last,
   output logic                      err,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_min_value,
   output logic [IDX_WIDTH-1:0]      out_min_index
);

   localparam int SEL_W = $clog2(INPUTS);
   localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   logic [CNT_W-1:0]     cnt_reg;
   logic [WIDTH-1:0]     acc_val_reg;
   logic [IDX_WIDTH-1:0] acc_idx_reg;
   logic                 out_valid_reg;
   logic [WIDTH-1:0]     out_val_reg;
   logic [IDX_WIDTH-1:0] out_idx_reg;

   logic [WIDTH-1:0]     beat_val;
   logic [SEL_W-1:0]     beat_sel;
   logic [IDX_WIDTH-1:0] beat_idx;
   logic                 accept;
   logic                 is_first;
   logic                 is_last;
   logic                 take_beat;
   logic [WIDTH-1:0]     win_val;
   logic [IDX_WIDTH-1:0] win_idx;

   argmin #(
      .WIDTH  (WIDTH),
      .INPUTS (INPUTS)
   ) u_argmin (
      .words     (in_words),
      .min_value (beat_val),
      .min_index (beat_sel)
   );

   // Ready depends only on registered out_valid and the downstream ready.
   assign in_ready = !out_valid_reg || out_ready;
   assign accept   = in_valid && in_ready;
   assign is_first = (cnt_reg == '0);
   assign is_last  = (cnt_reg == CNT_W'(CHUNKS - 1));

   // Global disparity = chunk * INPUTS + lane.
   assign beat_idx  = (IDX_WIDTH'(cnt_reg) << SEL_W) | IDX_WIDTH'(beat_sel);
   // Strict compare: on a cross-chunk tie the earlier chunk is kept.
   assign take_beat = is_first || (beat_val < acc_val_reg);
   assign win_val   = take_beat ? beat_val : acc_val_reg;
   assign win_idx   = take_beat ? beat_idx : acc_idx_reg;

   assign out_valid     = out_valid_reg;
   assign out_min_value = out_val_reg;
   assign out_min_index = out_idx_reg;

   // Chunk framing, running minimum and result register with handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg       <= '0;
         acc_val_reg   <= '0;
         acc_idx_reg   <= '0;
         out_valid_reg <= 1'b0;
         out_val_reg   <= '0;
         out_idx_reg   <= '0;
      end else begin
         if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
         if (accept) begin
            if (is_last) begin
               out_val_reg   <= win_val;
               out_idx_reg   <= win_idx;
               out_valid_reg <= 1'b1;
               cnt_reg       <= '0;
            end else begin
               acc_val_reg <= win_val;
               acc_idx_reg <= win_idx;
               cnt_reg     <= cnt_reg + CNT_W'(1);
            end
         end
      end
   end

`ifdef ARGMIN_SEQ_LAST_CHECK_EN
   logic err_reg;

   assign err = err_reg;

   // Sticky flag: in_last disagreed with the counter's view of the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (accept && (in_last != is_last)) begin
         err_reg <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_argmin_sequencer.sv
// Testbench for argmin_sequencer (WIDTH=7, INPUTS=8, CHUNKS=4).
module tb_argmin_sequencer;

   localparam int W  = 7;
   localparam int N  = 8;
   localparam int C  = 4;
   localparam int IW = 5;
   localparam int D  = N * C;

   typedef struct {
      logic [D*W-1:0] words;
      logic [W-1:0]   val;
      int             chunk;
   } exp_t;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_words;
   logic           in_last;
   logic           err;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_min_value;
   logic [IW-1:0]  out_min_index;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_results = 0;
   int   stall_cycles = 0;

   argmin_sequencer #(
      .WIDTH  (W),
      .INPUTS (N),
      .CHUNKS (C)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_words      (in_words),
`ifdef ARGMIN_SEQ_LAST_CHECK_EN
      .in_last       (in_last),
      .err           (err),
`endif
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_min_value (out_min_value),
      .out_min_index (out_min_index)
   );

`ifndef ARGMIN_SEQ_LAST_CHECK_EN
   assign err = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: compare each consumed result against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_results++;
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL result_unexpected got value=%0d index=%0d, required no result",
                     out_min_value, out_min_index);
         end else begin
            n_pass++;
            mon_e = sb_q.pop_front();
            n_checks++;
            if (out_min_value !== mon_e.val)
               $display("FAIL result_value got %0d, required %0d", out_min_value, mon_e.val);
            else n_pass++;
            n_checks++;
            if ((int'(out_min_index) / N) !== mon_e.chunk)
               $display("FAIL result_chunk got index %0d (chunk %0d), required chunk %0d",
                        out_min_index, int'(out_min_index) / N, mon_e.chunk);
            else n_pass++;
            n_checks++;
            if (mon_e.words[int'(out_min_index)*W +: W] !== mon_e.val)
               $display("FAIL result_index_word index %0d holds %0d, required %0d",
                        out_min_index, mon_e.words[int'(out_min_index)*W +: W], mon_e.val);
            else n_pass++;
            $display("result value=%0d index=%0d", out_min_value, out_min_index);
         end
      end
   end

   function automatic logic [D*W-1:0] fill(input logic [W-1:0] v);
      logic [D*W-1:0] r;
      for (int d = 0; d < D; d++) r[d*W +: W] = v;
      return r;
   endfunction

   // Expected result: global minimum and the earliest chunk holding it.
   function automatic void push_expect(input logic [D*W-1:0] pix);
      exp_t e;
      logic [W-1:0] m;
      m = pix[0 +: W];
      for (int d = 1; d < D; d++) if (pix[d*W +: W] < m) m = pix[d*W +: W];
      e.words = pix;
      e.val   = m;
      e.chunk = -1;
      for (int d = D - 1; d >= 0; d--) if (pix[d*W +: W] == m) e.chunk = d / N;
      sb_q.push_back(e);
   endfunction

   task automatic drive_beat(input logic [N*W-1:0] w, input logic last);
      int waited;
      in_words = w;
      in_last  = last;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      stall_cycles += waited;
      if (!in_ready) begin
         n_checks++;
         $display("FAIL beat_accept_timeout in_ready=0 after 100 cycles, required 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pixel(input logic [D*W-1:0] pix, input int bad_last);
      push_expect(pix);
      for (int c = 0; c < C; c++)
         drive_beat(pix[c*N*W +: N*W], (c == C - 1) || (c == bad_last));
   endtask

   task automatic test_reset();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b, required 0", out_valid);
      else n_pass++;
      n_checks++;
      if (out_min_value !== '0) $display("FAIL reset_value got %0d, required 0", out_min_value);
      else n_pass++;
      n_checks++;
      if (out_min_index !== '0) $display("FAIL reset_index got %0d, required 0", out_min_index);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b, required 1", in_ready);
      else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL reset_err got %0b, required 0", err);
      else n_pass++;
   endtask

   task automatic test_first_pixel();
      logic [D*W-1:0] pix;
      pix = fill(7'd127);
      for (int k = 0; k < N; k++) pix[k*W +: W] = W'(k + 1);
      drive_pixel(pix, -1);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_min_value !== 7'd1 || out_min_index !== 5'd0)
         $display("FAIL first_latency got valid=%0b value=%0d index=%0d, required 1/1/0",
                  out_valid, out_min_value, out_min_index);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL first_clear got %0b, required 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_mid_chunk_min();
      logic [D*W-1:0] pix;
      pix = fill(7'd0);
      for (int d = 0; d < D; d++) pix[d*W +: W] = W'(5 + (d * 3) % 90);
      pix[20*W +: W] = 7'd0;
      drive_pixel(pix, -1);
      in_valid = 1'b0;
      n_checks++;
      if (out_min_value !== 7'd0 || out_min_index !== 5'd20)
         $display("FAIL mid_chunk got value=%0d index=%0d, required 0/20",
                  out_min_value, out_min_index);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_all_equal();
      drive_pixel(fill(7'd100), -1);
      in_valid = 1'b0;
      n_checks++;
      if (out_min_value !== 7'd100 || out_min_index >= 5'd8)
         $display("FAIL all_equal got value=%0d index=%0d, required 100 with index 0..7",
                  out_min_value, out_min_index);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic [D*W-1:0] pa;
      logic [D*W-1:0] pb;
      pa = fill(7'd40);
      pa[31*W +: W] = 7'd3;
      pb = fill(7'd50);
      pb[9*W +: W] = 7'd9;
      out_ready = 1'b0;
      drive_pixel(pa, -1);
      push_expect(pb);
      in_words = pb[0 +: N*W];
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %0b, required 0", in_ready);
         else n_pass++;
         n_checks++;
         if (out_valid !== 1'b1 || out_min_value !== 7'd3 || out_min_index !== 5'd31)
            $display("FAIL bp_hold got valid=%0b value=%0d index=%0d, required 1/3/31",
                     out_valid, out_min_value, out_min_index);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b, required 1", in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL bp_consumed got %0b, required 0", out_valid);
      else n_pass++;
      for (int c = 1; c < C; c++) drive_beat(pb[c*N*W +: N*W], c == C - 1);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_min_value !== 7'd9 || out_min_index !== 5'd9)
         $display("FAIL bp_pixel_b got valid=%0b value=%0d index=%0d, required 1/9/9",
                  out_valid, out_min_value, out_min_index);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_pixel();
      logic [D*W-1:0] pix;
      int base;
      drive_beat(fill(7'd0) >> 0, 1'b0);
      drive_beat(fill(7'd0) >> 0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL rst_mid_no_result got %0b, required 0", out_valid);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      base = n_results;
      pix = fill(7'd60);
      pix[13*W +: W] = 7'd12;
      drive_pixel(pix, -1);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (n_results - base !== 1)
         $display("FAIL rst_mid_result_count got %0d, required 1", n_results - base);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [D*W-1:0] pix;
      int base;
      base = n_results;
      stall_cycles = 0;
      for (int p = 0; p < 6; p++) begin
         for (int d = 0; d < D; d++) pix[d*W +: W] = W'($urandom_range(2, 25));
         drive_pixel(pix, -1);
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (stall_cycles !== 0) $display("FAIL b2b_stalls got %0d, required 0", stall_cycles);
      else n_pass++;
      n_checks++;
      if (n_results - base !== 6) $display("FAIL b2b_count got %0d, required 6", n_results - base);
      else n_pass++;
   endtask

`ifdef ARGMIN_SEQ_LAST_CHECK_EN
   task automatic test_last_check();
      logic [D*W-1:0] pix;
      pix = fill(7'd70);
      pix[6*W +: W] = 7'd15;
      push_expect(pix);
      for (int c = 0; c < C; c++) begin
         drive_beat(pix[c*N*W +: N*W], (c == C - 1) || (c == 1));
         if (c == 1) begin
            n_checks++;
            if (err !== 1'b1) $display("FAIL err_set got %0b, required 1", err);
            else n_pass++;
         end
      end
      drive_pixel(fill(7'd33), -1);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (err !== 1'b1) $display("FAIL err_sticky got %0b, required 1", err);
      else n_pass++;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (err !== 1'b0) $display("FAIL err_cleared got %0b, required 0", err);
      else n_pass++;
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_words  = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_first_pixel();
      test_mid_chunk_min();
      test_all_equal();
      test_backpressure();
      test_reset_mid_pixel();
      test_back_to_back();
`ifdef ARGMIN_SEQ_LAST_CHECK_EN
      test_last_check();
`endif
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (sb_q.size() !== 0) $display("FAIL scoreboard_drain got %0d pending, required 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/argmin_sequencer.md
# argmin_sequencer

Sequential disparity selector for the SGM cost-aggregation back end. It time-multiplexes one combinational `argmin` instance (INPUTS lanes) over a pixel's full cost vector, delivered as CHUNKS consecutive beats. It keeps a running minimum and global index across beats and hands one (min value, disparity index) result per pixel to the downstream disparity writer. Both sides use valid/ready handshakes.

## Interface
Parameters:
- WIDTH, 7, bit width of one cost word.
- INPUTS, 8, cost words per beat; must be a power of two, ≥2; passed to the internal `argmin`.
- CHUNKS, 8, beats per pixel; ≥1; total disparities D = INPUTS*CHUNKS.
- IDX_WIDTH, clog2(INPUTS*CHUNKS), local parameter; width of the disparity index.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  beat available on in_words.
- in_ready  out  1  sequencer accepts the beat this cycle.
- in_words  in  WIDTH*INPUTS  packed costs; word k is at bits [k*WIDTH +: WIDTH] and is disparity chunk*INPUTS+k.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream takes the result.
- out_min_value  out  WIDTH  minimum cost of the pixel.
- out_min_index  out  IDX_WIDTH  disparity of the minimum.
- in_last  in  1  present only with ARGMIN_SEQ_LAST_CHECK_EN.
- err  out  1  present only with ARGMIN_SEQ_LAST_CHECK_EN.

## Operation
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational from registered out_valid; there is no path from in_valid.
- The chunk counter cnt (0..CHUNKS-1) is the state:
  - FIRST: cnt==0.
  - ACCUM: 0<cnt<CHUNKS-1.
  - LAST: cnt==CHUNKS-1.
  - An accepted beat advances cnt. It wraps to 0 after LAST.
- On an accepted beat, the internal `argmin` yields (v, k). Global index g = {cnt, k}, i.e. cnt*INPUTS+k.
  - FIRST: acc_val←v, acc_idx←g.
  - ACCUM: replace acc only if v < acc_val (strict). On a tie the earlier chunk wins.
  - LAST: apply the same strict compare against acc. Load the winner into out_min_value/out_min_index and set out_valid←1. acc is free for the next pixel.
  - CHUNKS==1: every beat is both FIRST and LAST; the result is (v, k) directly.
- Tie rule within one beat: the internal `argmin` decides the lane. Any lane holding the minimum is legal.
- out_valid clears on consume, unless a LAST beat is accepted in the same cycle; then it stays 1 with the new result.
- Output registers are stable while out_valid && !out_ready.
- Reset mid-pixel:
  - cnt, acc and out_valid are cleared.
  - The partial pixel is discarded and produces no result.
  - The next accepted beat is treated as FIRST.

## Timing
- Reset values:
  - out_valid=0, out_min_value=0, out_min_index=0.
  - cnt=0, acc_val=0, acc_idx=0, err=0.
  - in_ready=1 (because out_valid=0).
- Latency: the LAST beat is accepted at edge t; out_valid=1 and the result are visible after edge t (one cycle).
- Throughput: one beat per cycle. With out_ready held high, one pixel per CHUNKS cycles with no bubbles.
- Backpressure: while out_valid && !out_ready, in_ready=0 for every beat, including FIRST/ACCUM beats of the next pixel.
- No combinational path from in_valid to any output or to in_ready.

## Configuration
- Macro: ARGMIN_SEQ_LAST_CHECK_EN.
- Defined:
  - The in_last and err ports exist.
  - On each accepted beat, err is set if in_last != (cnt==CHUNKS-1).
  - err is sticky and is cleared only by rst.
  - Datapath behaviour is unchanged: cnt still governs framing, and in_last never alters results.
- Not defined: the ports and the check logic are absent; the rest of the block is identical.

## Test plan
Bench parameters: WIDTH=7, INPUTS=8, CHUNKS=4 (IDX_WIDTH=5). out_ready=1 unless stated.
1. Chunk0 = 1..8 (word0=1), chunks 1-3 all 127 -> one cycle after beat 4: out_valid=1, value 1, index 0; out_valid=0 the following cycle.
2. Word 4 of chunk 2 = 0, all others ≥5 -> value 0, index 20.
3. All 32 words = 100 -> value 100, index in 0..7 (chunk 0 wins across chunks). Check that the index points to a word equal to 100.
4. Pixel A (min 3 at index 31), out_ready=0 for 5 cycles; pixel B (min 9 at index 9) offered with in_valid held high. Required behaviour:
   - in_ready=0 and A's outputs stable throughout.
   - Raise out_ready -> A consumed, and B's first beat accepted in the same cycle.
   - B yields value 9, index 9.
5. rst high for one cycle after 2 beats of a pixel -> no out_valid. The next 4-beat pixel (min 12 at index 13) yields exactly one result: 12/13.
6. With ARGMIN_SEQ_LAST_CHECK_EN: in_last=1 on beat 2 -> err=1 the next cycle and it stays 1 through later correct pixels until rst. The result of that pixel is still correct.
